// File: rtl/float_divider_32bit.sv
// IEEE-754 single-precision divider: special-case shortcut, 26-cycle
// restoring mantissa division, one-cycle round-to-nearest-even, then
// a one-cycle done pulse. Subnormal operands are flushed to zero.
module float_divider_32bit #(
  parameter int MANT_ITER = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {IDLE, SPEC, DIV, ROUND, DONE} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            a_q, b_q;
  logic [24:0]            rem_q;
  logic [MANT_ITER-1:0]   quo_q;
  logic [4:0]             cnt_q;
  logic                   busy_q, done_q;
  logic [31:0]            result_q;
  logic [3:0]             flags_q;

  // Zero (incl. flushed subnormal), inf or NaN on either side skips the divider
  function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  // Returns {flags[3:0], result[31:0]} for a special-case operand pair
  function automatic logic [35:0] special_case(input logic [31:0] x, input logic [31:0] y);
    logic s, xn, xi, xz, yn, yi, yz;
    logic [35:0] r;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    xz = (x[30:23] == 8'h00);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    yz = (y[30:23] == 8'h00);
    if (xn || yn || (xz && yz) || (xi && yi)) r = {4'b1000, 32'h7FC00000};
    else if (xi)                              r = {4'b0000, s, 8'hFF, 23'd0};
    else if (yi || xz)                        r = {4'b0000, s, 31'd0};
    else                                      r = {4'b0100, s, 8'hFF, 23'd0};
    return r;
  endfunction

  logic [35:0] spec_q;
  logic [24:0] diff;
  logic        ge;
  logic        norm, g, rb, stk, rnd_up, sgn, ovf, unf;
  logic [23:0] mant;
  logic [24:0] msum;
  logic [9:0]  exp0, exp1;
  logic [22:0] frac;

  // Divider step, rounding and range check, all from registered operands
  always_comb begin
    spec_q = special_case(a_q, b_q);
    diff   = rem_q - {1'b0, 1'b1, b_q[22:0]};
    ge     = (rem_q >= {1'b0, 1'b1, b_q[22:0]});
    norm   = quo_q[MANT_ITER-1];
    mant   = norm ? quo_q[25:2] : quo_q[24:1];
    g      = norm ? quo_q[1] : quo_q[0];
    rb     = norm & quo_q[0];
    stk    = |rem_q;
    rnd_up = g & (rb | stk | mant[0]);
    msum   = {1'b0, mant} + {24'd0, rnd_up};
    exp0   = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'd127 - {9'd0, ~norm};
    exp1   = exp0 + {9'd0, msum[24]};
    frac   = msum[24] ? msum[23:1] : msum[22:0];
    sgn    = a_q[31] ^ b_q[31];
    ovf    = $signed(exp1) >= $signed(10'd255);
    unf    = $signed(exp1) <= $signed(10'd0);
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = is_special(a, b) ? SPEC : DIV;
      SPEC:    state_d = DONE;
      DIV:     if (cnt_q == 5'(MANT_ITER - 1)) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand capture, iterative division, result/flag update, handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0; b_q <= '0; rem_q <= '0; quo_q <= '0; cnt_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; result_q <= '0; flags_q <= '0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == IDLE && start) busy_q <= 1'b1;
      else if (done_q)              busy_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          rem_q <= {2'b01, a[22:0]};
          quo_q <= '0;
          cnt_q <= '0;
        end
        SPEC: begin
          result_q <= spec_q[31:0];
          flags_q  <= spec_q[35:32];
        end
        DIV: begin
          quo_q <= {quo_q[MANT_ITER-2:0], ge};
          rem_q <= ge ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        ROUND: begin
          if (ovf) begin
            result_q <= {sgn, 8'hFF, 23'd0};
            flags_q  <= 4'b0010;
          end else if (unf) begin
            result_q <= {sgn, 31'd0};
            flags_q  <= 4'b0001;
          end else begin
            result_q <= {sgn, exp1[7:0], frac};
            flags_q  <= 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_float_divider_32bit.sv
// Bench for float_divider_32bit: directed vectors with literal expectations
// plus an arithmetic reference model compared against the outputs each cycle.
module tb_float_divider_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  float_divider_32bit #(.MANT_ITER(26)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference quotient: {special, flags, result}, via wide integer division
  function automatic logic [36:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic s, xn, xi, xz, yn, yi, yz, up;
    longint unsigned n, q, r, m, rbits, half;
    int e, sh;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    xz = (x[30:23] == 8'h00);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    yz = (y[30:23] == 8'h00);
    if (xn || yn || (xz && yz) || (xi && yi)) return {1'b1, 4'b1000, 32'h7FC00000};
    if (xi)       return {1'b1, 4'b0000, s, 8'hFF, 23'd0};
    if (yi || xz) return {1'b1, 4'b0000, s, 31'd0};
    if (yz)       return {1'b1, 4'b0100, s, 8'hFF, 23'd0};
    n = longint'({1'b1, x[22:0]}) << 40;
    q = n / longint'({1'b1, y[22:0]});
    r = n % longint'({1'b1, y[22:0]});
    e = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin sh = 16; e = e - 1; end
    m     = q >> sh;
    rbits = q & ((64'd1 << sh) - 1);
    half  = 64'd1 << (sh - 1);
    up    = (rbits > half) || (rbits == half && (r != 0 || m[0]));
    if (up) m = m + 1;
    if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {1'b0, 4'b0010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, 4'b0001, s, 31'd0};
    return {1'b0, 4'b0000, s, 8'(e), m[22:0]};
  endfunction

  // Timing model: edges remaining until done, pending result
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_res = '0, p_res = '0;
  logic [3:0]  m_flg = '0, p_flg = '0;
  logic [36:0] m_r;
  int          m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_flg = '0; m_left = 0;
    end else begin
      if (m_done) begin m_done = 1'b0; m_busy = 1'b0; end
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 1) begin m_res = p_res; m_flg = p_flg; end
        if (m_left == 0) m_done = 1'b1;
      end else if (start) begin
        m_r    = ref_div(a, b);
        p_res  = m_r[31:0];
        p_flg  = m_r[35:32];
        m_left = m_r[36] ? 2 : 28;
        m_busy = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    total++;
    if ({busy, done, result, flags} !== {m_busy, m_done, m_res, m_flg}) begin
      bad++;
      $display("FAIL cycle%0d act busy=%b done=%b res=%h flg=%b exp busy=%b done=%b res=%h flg=%b",
               cyc, busy, done, result, flags, m_busy, m_done, m_res, m_flg);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int n0, input string name, input int lat);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check({name, "_lat"}, got ? 32'(cyc - n0) : 32'hFFFFFFFF, 32'(lat));
  endtask

  task automatic run(input string name, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic [3:0] ef, input int lat);
    int n0;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n0 = cyc;
    wait_done(n0, name, lat);
    check({name, "_res"}, result, er);
    check({name, "_flg"}, 32'(flags), 32'(ef));
  endtask

  logic [36:0] pin;
  int          n0;

  initial begin
    // model pinned against hand values
    pin = ref_div(32'h3F800000, 32'h40400000);
    check("model_1_3", pin[31:0], 32'h3EAAAAAB);
    pin = ref_div(32'h7F000000, 32'h3E800000);
    check("model_ovf", 32'(pin[36:32]), 32'h02);

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_res",  result, 32'h0);
    check("rst_flg",  32'(flags), 0);
    rst = 1'b1;

    run("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    run("div1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
    run("neg",      32'hC0900000, 32'h3FC00000, 32'hC0400000, 4'b0000, 28);
    run("b2b",      32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    run("divzero",  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2);
    run("zero_zero",32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
    run("nan",      32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
    run("ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28);
    run("unf",      32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001, 28);
    run("fin_inf",  32'hBF800000, 32'h7F800000, 32'h80000000, 4'b0000, 2);
    run("inf_fin",  32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2);
    run("subnorm",  32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2);
    run("negdz",    32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 2);

    // start with new operands during DIV is ignored
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n0 = cyc;
    repeat (5) @(posedge clk);
    #1 a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n0, "ignore", 28);
    check("ignore_res", result, 32'h40400000);

    // reset mid-operation aborts with no done
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_res",  result, 32'h0);
    check("abort_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
